// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forward-select encodings, scoreboard states and default widths for the 5-stage pipeline.
package pipe_pkg;
    localparam int AW_DEF = 5;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
endpackage

// File: rtl/md_scoreboard.sv
// md_scoreboard: tracks one in-flight mult/div op, counting down to its GPR write strobe.
module md_scoreboard
    import pipe_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int MD_LAT = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] dst_i,
    output logic          md_busy_o,
    output logic [AW-1:0] md_dst_o,
    output logic          md_wb_o
);
    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] dst_q, dst_d;
    logic          busy;
    assign busy = state_q == MD_BUSY;
    assign md_busy_o = busy;
    assign md_dst_o = dst_q;
    assign md_wb_o = busy && cnt_q == '0;
    // A new start overrides an expiring op; the write strobe still fires from current state.
    always_comb begin
        state_d = start_i ? MD_BUSY : md_wb_o ? MD_IDLE : state_q;
        cnt_d = start_i ? CW'(MD_LAT - 1) : (busy && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        dst_d = start_i ? dst_i : dst_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q <= '0;
            dst_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            dst_q <= dst_d;
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects plus load-use, branch-in-ID and mult/div stall generation.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int MD_LAT = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] dstD,
    input  logic          RegWriteD,
    input  logic          BranchD,
    input  logic          MdOpD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] dstE,
    input  logic          RegWriteE,
    input  logic          MemtoRegE,
    input  logic          MdStartE,
    input  logic [AW-1:0] dstM,
    input  logic [AW-1:0] dstW,
    input  logic          RegWriteM,
    input  logic          MemtoRegM,
    input  logic          RegWriteW,
    output logic [1:0]    forwardAE,
    output logic [1:0]    forwardBE,
    output logic [1:0]    forwardAD,
    output logic [1:0]    forwardBD,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          md_busy,
    output logic [AW-1:0] md_dst,
    output logic          md_wb
);
    logic m_alu, w_ok, e_hit, m_hit, lwstall, brstall, mdstall;
    md_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .CW(CW)) u_md (
        .clk      (clk),
        .rst      (rst),
        .start_i  (MdStartE),
        .dst_i    (dstE),
        .md_busy_o(md_busy),
        .md_dst_o (md_dst),
        .md_wb_o  (md_wb)
    );
    // Only ALU results are available in M; W carries both loads and ALU results.
    always_comb begin
        m_alu = RegWriteM && !MemtoRegM && dstM != '0;
        w_ok = RegWriteW && dstW != '0;
        forwardAE = (m_alu && dstM == rsE) ? FWD_MEM : (w_ok && dstW == rsE) ? FWD_WB : FWD_REG;
        forwardBE = (m_alu && dstM == rtE) ? FWD_MEM : (w_ok && dstW == rtE) ? FWD_WB : FWD_REG;
        forwardAD = {1'b0, m_alu && dstM == rsD};
        forwardBD = {1'b0, m_alu && dstM == rtD};
        e_hit = dstE != '0 && (dstE == rsD || dstE == rtD);
        m_hit = dstM != '0 && (dstM == rsD || dstM == rtD);
        lwstall = MemtoRegE && e_hit;
        brstall = BranchD && ((RegWriteE && e_hit) || (MemtoRegM && m_hit));
        mdstall = md_busy && (MdOpD || (md_dst != '0 &&
                  (md_dst == rsD || md_dst == rtD || (RegWriteD && dstD == md_dst))));
        stallF = lwstall | brstall | mdstall;
        stallD = stallF;
        flushE = stallF;
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench; expectations queued at drive time and checked on the falling edge.
module tb_hazard_unit;
    localparam int AW = 5;
    logic clk = 0, rst = 1;
    logic [AW-1:0] rsD, rtD, dstD, rsE, rtE, dstE, dstM, dstW;
    logic RegWriteD, BranchD, MdOpD, RegWriteE, MemtoRegE, MdStartE;
    logic RegWriteM, MemtoRegM, RegWriteW;
    logic [1:0] forwardAE, forwardBE, forwardAD, forwardBD;
    logic stallF, stallD, flushE, md_busy, md_wb;
    logic [AW-1:0] md_dst;
    int n_chk = 0, n_fail = 0;
    typedef struct {
        string tag;
        logic [3:0] fe;
        logic [3:0] fd;
        logic s;
        logic busy;
        logic wb;
        logic [AW-1:0] dst;
    } exp_t;
    exp_t q[$];
    hazard_unit #(.AW(AW), .MD_LAT(4), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .dstD(dstD),
        .RegWriteD(RegWriteD), .BranchD(BranchD), .MdOpD(MdOpD),
        .rsE(rsE), .rtE(rtE), .dstE(dstE),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MdStartE(MdStartE),
        .dstM(dstM), .dstW(dstW),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .RegWriteW(RegWriteW),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .md_busy(md_busy), .md_dst(md_dst), .md_wb(md_wb)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".fwdE"}, {28'd0, forwardAE, forwardBE}, {28'd0, e.fe});
            check({e.tag, ".fwdD"}, {28'd0, forwardAD, forwardBD}, {28'd0, e.fd});
            check({e.tag, ".stall"}, {29'd0, stallF, stallD, flushE}, {29'd0, {3{e.s}}});
            check({e.tag, ".md"}, {30'd0, md_busy, md_wb}, {30'd0, e.busy, e.wb});
            if (e.busy) check({e.tag, ".md_dst"}, {27'd0, md_dst}, {27'd0, e.dst});
        end
    end
    task automatic clr();
        {rsD, rtD, dstD, rsE, rtE, dstE, dstM, dstW} = '0;
        {RegWriteD, BranchD, MdOpD, RegWriteE, MemtoRegE, MdStartE} = '0;
        {RegWriteM, MemtoRegM, RegWriteW} = '0;
    endtask
    task automatic step(input string tag, input logic [3:0] fe, input logic [3:0] fd,
                        input logic s, input logic busy, input logic wb, input logic [AW-1:0] dst);
        exp_t e;
        e.tag = tag; e.fe = fe; e.fd = fd; e.s = s; e.busy = busy; e.wb = wb; e.dst = dst;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    initial begin
        clr();
        #12 rst = 0;
        @(posedge clk); #1;
        step("rst", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); RegWriteM = 1; dstM = 3; rsE = 3;
        step("alu_m", 4'b1000, 4'b0000, 0, 0, 0, 0);
        RegWriteW = 1; dstW = 3;
        step("m_prio", 4'b1000, 4'b0000, 0, 0, 0, 0);
        clr(); MemtoRegE = 1; RegWriteE = 1; dstE = 5; rtD = 5;
        step("lu_stall", 4'b0000, 4'b0000, 1, 0, 0, 0);
        clr(); RegWriteW = 1; dstW = 5; rtE = 5;
        step("lu_fwd", 4'b0001, 4'b0000, 0, 0, 0, 0);
        clr(); BranchD = 1; rsD = 7; RegWriteE = 1; dstE = 7;
        step("br_stall", 4'b0000, 4'b0000, 1, 0, 0, 0);
        clr(); BranchD = 1; rsD = 7; RegWriteM = 1; dstM = 7;
        step("br_fwd", 4'b0000, 4'b0100, 0, 0, 0, 0);
        clr(); BranchD = 1; rsD = 7; RegWriteM = 1; MemtoRegM = 1; dstM = 7;
        step("br_load", 4'b0000, 4'b0000, 1, 0, 0, 0);
        clr(); RegWriteM = 1; RegWriteW = 1; MemtoRegE = 1; BranchD = 1; RegWriteE = 1;
        step("zero", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); MdStartE = 1; RegWriteE = 1; dstE = 9;
        step("md_t0", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); rsD = 2;
        step("md_t1_unrel", 4'b0000, 4'b0000, 0, 1, 0, 9);
        clr(); MdOpD = 1;
        step("md_t2_struct", 4'b0000, 4'b0000, 1, 1, 0, 9);
        clr(); RegWriteD = 1; dstD = 9;
        step("md_t3_waw", 4'b0000, 4'b0000, 1, 1, 0, 9);
        clr(); rsD = 9;
        step("md_t4_wb", 4'b0000, 4'b0000, 1, 1, 1, 9);
        step("md_t5_rel", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); MdStartE = 1; dstE = 9;
        step("rs_t0", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); rsD = 9;
        step("rs_t1", 4'b0000, 4'b0000, 1, 1, 0, 9);
        rst = 1;
        #1;
        check("async_rst.busy", {31'd0, md_busy}, 32'd0);
        check("async_rst.dst", {27'd0, md_dst}, 32'd0);
        check("async_rst.stall", {31'd0, stallD}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) step("rs_quiet", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); MdStartE = 1; dstE = 4;
        step("re_t0", 4'b0000, 4'b0000, 0, 0, 0, 0);
        clr(); rtD = 4;
        step("re_t1", 4'b0000, 4'b0000, 1, 1, 0, 4);
        step("re_t2", 4'b0000, 4'b0000, 1, 1, 0, 4);
        step("re_t3", 4'b0000, 4'b0000, 1, 1, 0, 4);
        step("re_t4", 4'b0000, 4'b0000, 1, 1, 1, 4);
        step("re_t5", 4'b0000, 4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Next-generation hazard/forwarding block for the 5-stage pipeline (F/D/E/M/W).
- Generalises the EX/ID forwarding muxes to a parametrised register-address width.
- Adds load-use and branch-in-ID stall generation.
- Adds a scoreboard with a down-counter tracking one in-flight long-latency mult/div op that writes a GPR. Sits beside the datapath and drives its forward selects and the F/D stall/E flush controls.

Parameters:
- AW, 5, register-address width; address 0 is hard-wired zero and never forwarded or scoreboarded.
- MD_LAT, 8, cycles from mult/div issue in E to its GPR write (2..255).
- CW, 8, counter width; must satisfy MD_LAT < 2**CW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rsD, rtD, dstD  in  AW  ID-stage sources and destination.
- RegWriteD, BranchD, MdOpD  in  1  ID instruction writes a GPR / is a branch or jump-register comparing in ID / is a mult/div.
- rsE, rtE, dstE  in  AW  EX-stage sources and destination.
- RegWriteE, MemtoRegE, MdStartE  in  1  EX controls; MdStartE = a mult/div is in E this cycle.
- dstM, dstW  in  AW  MEM/WB destinations.
- RegWriteM, MemtoRegM, RegWriteW  in  1  MEM/WB controls.
- forwardAE, forwardBE  out  2  00 regfile, 01 WB result, 10 MEM ALU result.
- forwardAD, forwardBD  out  2  00 regfile, 01 MEM ALU result.
- stallF, stallD, flushE  out  1  hold PC / hold IF-ID / bubble into ID-EX.
- md_busy  out  1  mult/div in flight.
- md_dst  out  AW  destination of the in-flight op.
- md_wb  out  1  one-cycle strobe: the datapath writes the md result to md_dst this cycle.

Behaviour:
- Forward E (combinational): the M match wins over W. For each of rsE/rtE:
  - 10 if RegWriteM && !MemtoRegM && dstM!=0 && dstM==src.
  - else 01 if RegWriteW && dstW!=0 && dstW==src. Loads and ALU results both qualify for W.
  - else 00.
- Forward D (combinational): 01 if RegWriteM && !MemtoRegM && dstM!=0 && dstM==src; else 00.
- lwstall = MemtoRegE && dstE!=0 && (dstE==rsD || dstE==rtD).
- brstall = BranchD && ((RegWriteE && dstE!=0 && dstE∈{rsD,rtD}) || (MemtoRegM && dstM!=0 && dstM∈{rsD,rtD})).
- mdstall = md_busy && (MdOpD || (md_dst!=0 && (md_dst∈{rsD,rtD} || (RegWriteD && dstD==md_dst)))). This covers RAW, WAW and structural hazards.
- stallF = stallD = flushE = lwstall | brstall | mdstall. All are combinational from inputs and registered state; none are registered.
- Scoreboard, registered. State IDLE (md_busy=0) / BUSY (md_busy=1), with counter cnt[CW-1:0].
  - IDLE, MdStartE=1: go to BUSY, cnt<=MD_LAT-1, md_dst<=dstE.
  - BUSY, cnt>0: cnt<=cnt-1.
  - BUSY, cnt==0: md_wb=1 this cycle (combinational from state), go to IDLE next edge. md_busy stays 1 during the md_wb cycle.
  - MdStartE while BUSY cannot occur, because mdstall holds MdOpD in D. If it is presented anyway, start wins: reload cnt/md_dst, stay BUSY, and md_wb still pulses if cnt==0.
  - md_dst==0 is legal: md_wb still pulses, and only the structural stall applies.
- Reset (async): md_busy=0, cnt=0, md_dst=0, md_wb=0. Stall and forward outputs follow inputs. Reset mid-operation drops the op with no md_wb pulse.
- Latency: issue in E at cycle t gives md_wb at cycle t+MD_LAT. The dependent instruction leaves D at cycle t+MD_LAT+1, because the regfile writes on the clock edge.

Decomposition:
- Shared package pipe_pkg holds:
  - forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - state enum {MD_IDLE, MD_BUSY};
  - AW default.
- One natural sub-module: md_scoreboard, holding the counter, the FSM and md_dst, and exporting md_busy, md_dst and md_wb. Forward and stall logic stay in the top.

Test Plan:
- ALU back-to-back: add dstM=3/RegWriteM=1, rsE=3 -> forwardAE=10. Add dstW=3 in the same cycle -> still 10 (M priority).
- Load-use: MemtoRegE=1, dstE=5, rtD=5 -> stallF=stallD=flushE=1 for one cycle. Next cycle, load in W with rtE=5 -> forwardBE=01.
- Branch: BranchD=1, rsD=7, RegWriteE=1, dstE=7 -> stall 1 cycle. Next cycle, ALU result in M -> forwardAD=01, no stall. Load to r7 in M with BranchD -> stall.
- Zero register: RegWriteM=1, dstM=0, rsE=0 -> forwardAE=00. MemtoRegE=1, dstE=0, rsD=0 -> no stall.
- Mult/div, MD_LAT=4: MdStartE at t with dstE=9. Then:
  - md_busy=1 for t+1..t+4, md_wb=1 only at t+4;
  - rsD=9 stalls through t+4 and releases at t+5;
  - MdOpD stalls;
  - RegWriteD, dstD=9 stalls;
  - an unrelated rsD=2 does not stall.
- Async reset asserted at t+2 of an MD_LAT=4 op -> md_busy=0, md_dst=0 immediately, no md_wb pulse. The first MdStartE after release restarts cleanly.
